// File: rtl/score_keeper_pkg.sv
// Shared game definitions for the diamond score keeper.
// The FSM states, default sizing and the BCD helper used by the display path live here.
package score_keeper_pkg;

  localparam int NUM_DIAMONDS_DEF = 16;
  localparam int SCORE_W_DEF      = 5;
  localparam int IDX_W            = 4;
  localparam int MASK_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } game_state_e;

  // Scores never exceed 16, so a plain divide by a constant stays tiny in logic.
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] bin);
    logic [3:0] tens_v;
    logic [3:0] ones_v;
    tens_v = 4'(bin / 5'd10);
    ones_v = 4'(bin % 5'd10);
    return {tens_v, ones_v};
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Collect-event handshake between the game logic (master) and the score keeper (slave).
interface score_keeper_if;
  import score_keeper_pkg::*;

  logic             collect_valid;
  logic [IDX_W-1:0] collect_idx;
  logic             collect_ready;

  modport master (
    output collect_valid,
    output collect_idx,
    input  collect_ready
  );

  modport slave (
    input  collect_valid,
    input  collect_idx,
    output collect_ready
  );

endinterface

// File: rtl/score_bcd.sv
// Registered binary-to-BCD converter for scores 0..16.
// Fed with the next score value so its digits land on the same edge as the score register.
module score_bcd
  import score_keeper_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic [SCORE_W-1:0] bin_d,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  logic [3:0] tens_d;
  logic [3:0] ones_d;
  logic [3:0] tens_q;
  logic [3:0] ones_q;

  always_comb begin
    tens_d = 4'd0;
    ones_d = 4'd0;
    {tens_d, ones_d} = bin_to_bcd(5'(bin_d));
  end

  always_ff @(posedge clk) begin
    tens_q <= tens_d;
    ones_q <= ones_d;
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/score_keeper.sv
// Diamond score keeper: tracks which diamonds were collected in the current game,
// keeps a saturating score and its BCD digits for the seven-segment display.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int NUM_DIAMONDS = NUM_DIAMONDS_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input  logic               segclk,
  input  logic               reset,
  input  logic               start,
  score_keeper_if.slave      col,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic               all_collected,
  output logic               reject
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(NUM_DIAMONDS);
  localparam logic [IDX_W:0]     IDX_LIM   = (IDX_W + 1)'(NUM_DIAMONDS);

  game_state_e        state_q;
  game_state_e        state_d;
  logic [MASK_W-1:0]  mask_q;
  logic [MASK_W-1:0]  mask_d;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic               all_collected_q;
  logic               all_collected_d;
  logic               reject_q;
  logic               reject_d;
  logic               accept;
  logic               idx_ok;
  logic               already;
  logic [SCORE_W-1:0] disp_bin;

  // Ready is the only combinational output: start pre-empts any offered event.
  assign col.collect_ready = (state_q == ST_PLAY) && !start;
  assign accept            = col.collect_valid && col.collect_ready;
  assign idx_ok            = {1'b0, col.collect_idx} < IDX_LIM;
  assign already           = mask_q[col.collect_idx];

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    score_d  = score_q;
    reject_d = 1'b0;
    if (start) begin
      state_d = ST_PLAY;
      mask_d  = '0;
      score_d = '0;
    end else if (accept) begin
      if (!idx_ok || already) begin
        reject_d = 1'b1;
      end else if (score_q != SCORE_MAX) begin
        mask_d[col.collect_idx] = 1'b1;
        score_d                 = score_q + SCORE_W'(1);
        if (score_d == SCORE_MAX) begin
          state_d = ST_DONE;
        end
      end
    end
    all_collected_d = (state_d == ST_DONE);
  end

  always_ff @(posedge segclk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      mask_q          <= '0;
      score_q         <= '0;
      all_collected_q <= 1'b0;
      reject_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      score_q         <= score_d;
      all_collected_q <= all_collected_d;
      reject_q        <= reject_d;
    end
  end

  // The display path sees the cleared value during reset so its digits never lag the score.
  assign disp_bin = reset ? '0 : score_d;

  score_bcd #(
    .SCORE_W (SCORE_W)
  ) u_bcd (
    .clk   (segclk),
    .bin_d (disp_bin),
    .tens  (tens),
    .ones  (ones)
  );

  assign score         = score_q;
  assign all_collected = all_collected_q;
  assign reject        = reject_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter NUM_DIAMONDS, default 16, total collectable diamonds per game, legal range 1..16.
REQ-002 SHALL have parameter SCORE_W, default 5, score width, which SHALL hold the value NUM_DIAMONDS.
REQ-003 SHALL have port segclk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, new-game request, level sampled each cycle.
REQ-006 SHALL have port collect_valid, input, 1, game logic offers a collect event.
REQ-007 SHALL have port collect_idx, input, 4, diamond index of the offered event.
REQ-008 SHALL have port collect_ready, output, 1, the block accepts an event this cycle.
REQ-009 SHALL have port score, output, SCORE_W, diamonds collected in the current game, feeding the seven-segment display driver.
REQ-010 SHALL have port tens, output, 4, BCD tens digit of score.
REQ-011 SHALL have port ones, output, 4, BCD ones digit of score.
REQ-012 SHALL have port all_collected, output, 1, high while in state DONE.
REQ-013 SHALL have port reject, output, 1, one-cycle pulse when an accepted event is discarded.

Function
REQ-014 SHALL implement FSM states IDLE, PLAY and DONE.
REQ-015 SHALL move from IDLE to PLAY on start=1.
REQ-016 SHALL, on start=1 in any state, clear the collected mask, set score, tens and ones to 0 the next cycle, and enter PLAY.
REQ-017 SHALL drive collect_ready=1 only in PLAY with start=0; an event is accepted when collect_valid && collect_ready.
REQ-018 SHALL ignore collect_valid entirely outside PLAY or when start=1; no reject, no score change.
REQ-019 SHALL, on an accepted event with collect_idx < NUM_DIAMONDS and mask bit clear, set that mask bit and increment score by 1, visible the next cycle.
REQ-020 SHALL, on an accepted event whose mask bit is already set or whose collect_idx >= NUM_DIAMONDS, leave mask and score unchanged and pulse reject high for exactly the next cycle.
REQ-021 SHALL enter DONE in the cycle score becomes NUM_DIAMONDS; all_collected rises in that same cycle and collect_ready is 0 from then on.
REQ-022 SHALL keep score, tens, ones and all_collected stable in DONE until start or reset.
REQ-023 SHALL never let score exceed NUM_DIAMONDS or wrap; the increment is suppressed when score equals NUM_DIAMONDS.
REQ-024 SHALL update tens and ones in the same cycle as score (tens = score/10, ones = score%10); they are never stale relative to score.
REQ-025 SHALL give reset priority over start, and start priority over collect events.

Reset
REQ-026 SHALL, on reset=1, enter IDLE, clear the mask and drive score=0, tens=0, ones=0, collect_ready=0, all_collected=0 and reject=0 the following cycle.
REQ-027 SHALL, on reset during PLAY or DONE, discard any in-flight event and produce no reject pulse.

Structure
REQ-028 SHALL take state encoding (IDLE/PLAY/DONE) and the NUM_DIAMONDS default from a shared game package used by the game FSM and the display path.
REQ-029 SHALL contain one sub-module, score_bcd, a registered binary-to-BCD converter for 0..16 with no other state.
REQ-030 SHALL register every output; no combinational path from inputs to outputs except collect_ready, which depends on start and the state register.

Verification
REQ-031 SHALL cover: reset, then start, then idx 3,7,3 accepted on consecutive cycles -> score 1,2,2; reject pulses once, on the cycle after the third event; tens=0, ones=2.
REQ-032 SHALL cover: indices 0..15 offered once each -> score 16, tens=1, ones=6, all_collected=1 and collect_ready=0 in the cycle score reaches 16; a further event is ignored.
REQ-033 SHALL cover: NUM_DIAMONDS=10 with idx 12 offered -> reject pulse and score unchanged; then 10 distinct indices -> score 10, tens=1, ones=0, DONE.
REQ-034 SHALL cover: start and collect_valid both high in the same cycle at score 5 -> next cycle score 0, mask clear, no reject.
REQ-035 SHALL cover: reset asserted mid-game at score 9 with collect_valid high -> next cycle IDLE, score 0, no reject; collect ignored until start.
REQ-036 SHALL cover: collect_valid high in IDLE for 4 cycles -> score stays 0, collect_ready stays 0, no reject.
